// File: rtl/if_id_pipe_if.sv
// Handshake bundle for if_id_pipe: upstream/downstream valid-ready bus, flush and status.
// io_perf_cnt is carried only when IF_ID_PIPE_PERF_CNT_EN is defined.
interface if_id_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_bits;
  logic             io_flush;
  logic [1:0]       io_count;
`ifdef IF_ID_PIPE_PERF_CNT_EN
  logic [31:0]      io_perf_cnt;

  modport master (
    output io_in_valid, io_in_bits, io_out_ready, io_flush,
    input  io_in_ready, io_out_valid, io_out_bits, io_count, io_perf_cnt
  );
  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready, io_flush,
    output io_in_ready, io_out_valid, io_out_bits, io_count, io_perf_cnt
  );
`else
  modport master (
    output io_in_valid, io_in_bits, io_out_ready, io_flush,
    input  io_in_ready, io_out_valid, io_out_bits, io_count
  );
  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready, io_flush,
    output io_in_ready, io_out_valid, io_out_bits, io_count
  );
`endif
endinterface

// File: rtl/if_id_pipe.sv
// Two-stage (IF, ID) constant-multiply pipeline with valid/ready flow control and flush.
// Optional 32-bit output-transfer counter enabled by defining IF_ID_PIPE_PERF_CNT_EN.
module if_id_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned IF_MUL = 4,
  parameter int unsigned ID_MUL = 3
) (
  input logic         clock,
  input logic         reset,
  if_id_pipe_if.slave bus
);

  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] s1_bits;
  logic [WIDTH-1:0] s2_bits;
  logic [WIDTH-1:0] in_prod;
  logic [WIDTH-1:0] s1_prod;
  logic             s1_en;
  logic             s2_en;
  logic             in_fire;

  // Ready chain runs back from the output so a full pipe still moves every cycle.
  assign s2_en   = !s2_valid || bus.io_out_ready;
  assign s1_en   = !s1_valid || s2_en;
  assign in_fire = bus.io_in_valid && bus.io_in_ready;

  // Products wrap modulo 2^WIDTH at each stage.
  assign in_prod = bus.io_in_bits * WIDTH'(IF_MUL);
  assign s1_prod = s1_bits * WIDTH'(ID_MUL);

  assign bus.io_in_ready  = s1_en && !bus.io_flush;
  assign bus.io_out_valid = s2_valid && !bus.io_flush;
  assign bus.io_out_bits  = s2_bits;
  assign bus.io_count     = {1'b0, s1_valid} + {1'b0, s2_valid};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_bits  <= '0;
      s2_bits  <= '0;
    end else if (bus.io_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_en) begin
        s2_valid <= s1_valid;
        s2_bits  <= s1_prod;
      end
      if (s1_en) begin
        s1_valid <= in_fire;
        s1_bits  <= in_prod;
      end
    end
  end

`ifdef IF_ID_PIPE_PERF_CNT_EN
  logic        out_fire;
  logic [31:0] perf_cnt;

  assign out_fire        = bus.io_out_valid && bus.io_out_ready;
  assign bus.io_perf_cnt = perf_cnt;

  // Survives flush; only reset clears it. Wraps naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cnt <= 32'd0;
    end else if (out_fire) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe: driver queues hand-computed results, monitor pops on each output transfer.
module tb_if_id_pipe;

  logic clk;
  logic reset;

  if_id_pipe_if #(.WIDTH(32)) bus ();

  if_id_pipe #(.WIDTH(32), .IF_MUL(4), .ID_MUL(3)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int out_cnt;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.io_out_valid && bus.io_out_ready) begin
      out_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got 0x%08h expected no output", bus.io_out_bits);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.io_out_bits !== e) begin
          errors++;
          $display("FAIL out_bits: got 0x%08h expected 0x%08h", bus.io_out_bits, e);
        end
      end
    end
  end

  // One cycle of stimulus; returns 1 time unit after the clock edge that consumes it.
  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] e,
                       input logic rdy, input logic fl);
    bus.io_in_valid  = v;
    bus.io_in_bits   = d;
    bus.io_out_ready = rdy;
    bus.io_flush     = fl;
    @(negedge clk);
    if (fl) exp_q.delete();
    else if (v && bus.io_in_ready) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cnt;
`ifdef IF_ID_PIPE_PERF_CNT_EN
    logic [31:0] perf0;
`endif
    checks  = 0;
    errors  = 0;
    out_cnt = 0;
    reset   = 1'b1;
    bus.io_in_valid  = 1'b0;
    bus.io_in_bits   = 32'd0;
    bus.io_out_ready = 1'b1;
    bus.io_flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(bus.io_out_valid), 32'd0);
    chk("rst_count", 32'(bus.io_count), 32'd0);
    chk("rst_out_bits", bus.io_out_bits, 32'd0);
    chk("rst_in_ready", 32'(bus.io_in_ready), 32'd1);
`ifdef IF_ID_PIPE_PERF_CNT_EN
    chk("rst_perf", bus.io_perf_cnt, 32'd0);
`endif

    // Latency: 5 -> 60 exactly two cycles later
    drive(1'b1, 32'd5, 32'd60, 1'b1, 1'b0);
    chk("lat_c1_valid", 32'(bus.io_out_valid), 32'd0);
    chk("lat_c1_count", 32'(bus.io_count), 32'd1);
    idle(1'b1);
    chk("lat_c2_valid", 32'(bus.io_out_valid), 32'd1);
    chk("lat_c2_bits", bus.io_out_bits, 32'd60);
    idle(1'b1);

    // Per-stage wrap
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b1, 1'b0);
    idle(1'b1);
    chk("wrap_bits", bus.io_out_bits, 32'hFFFF_FFF4);
    idle(1'b1);

    // Backpressure: two words fill the pipe and the output holds
    drive(1'b1, 32'd1, 32'd12, 1'b0, 1'b0);
    drive(1'b1, 32'd2, 32'd24, 1'b0, 1'b0);
    chk("stall_count", 32'(bus.io_count), 32'd2);
    chk("stall_in_ready", 32'(bus.io_in_ready), 32'd0);
    chk("stall_bits", bus.io_out_bits, 32'd12);
    idle(1'b0);
    idle(1'b0);
    chk("stall_hold_bits", bus.io_out_bits, 32'd12);
    chk("stall_hold_valid", 32'(bus.io_out_valid), 32'd1);
    idle(1'b1);
    chk("drain_bits", bus.io_out_bits, 32'd24);
    chk("drain_count", 32'(bus.io_count), 32'd1);
    idle(1'b1);
    chk("drain_empty", 32'(bus.io_count), 32'd0);

    // Flush with two in flight and a concurrent input
    drive(1'b1, 32'd3, 32'd36, 1'b0, 1'b0);
    drive(1'b1, 32'd4, 32'd48, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(bus.io_count), 32'd2);
`ifdef IF_ID_PIPE_PERF_CNT_EN
    perf0 = bus.io_perf_cnt;
`endif
    bus.io_in_valid  = 1'b1;
    bus.io_in_bits   = 32'd7;
    bus.io_out_ready = 1'b1;
    bus.io_flush     = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.io_out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.io_in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    bus.io_flush = 1'b0;
    chk("flush_count", 32'(bus.io_count), 32'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("post_flush_count", 32'(bus.io_count), 32'd0);
`ifdef IF_ID_PIPE_PERF_CNT_EN
    chk("flush_perf", bus.io_perf_cnt, perf0);
`endif

    // Ten back-to-back words: all ten outputs land in consecutive cycles
    start_cnt = out_cnt;
`ifdef IF_ID_PIPE_PERF_CNT_EN
    perf0 = bus.io_perf_cnt;
`endif
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i), 32'(12 * i), 1'b1, 1'b0);
      chk("stream_in_ready", 32'(bus.io_in_ready), 32'd1);
    end
    idle(1'b1);
    idle(1'b1);
    chk("stream_outputs", 32'(out_cnt - start_cnt), 32'd10);
`ifdef IF_ID_PIPE_PERF_CNT_EN
    chk("stream_perf", bus.io_perf_cnt, perf0 + 32'd10);
`endif

    // Reset mid-stream discards everything in flight
    drive(1'b1, 32'd20, 32'd240, 1'b1, 1'b0);
    drive(1'b1, 32'd21, 32'd252, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(bus.io_out_valid), 32'd0);
    chk("midrst_count", 32'(bus.io_count), 32'd0);
    chk("midrst_bits", bus.io_out_bits, 32'd0);
`ifdef IF_ID_PIPE_PERF_CNT_EN
    chk("midrst_perf", bus.io_perf_cnt, 32'd0);
`endif
    reset = 1'b0;
    bus.io_in_valid = 1'b0;
    chk("midrst_in_ready", 32'(bus.io_in_ready), 32'd1);

    // Pipe resumes normally after reset
    drive(1'b1, 32'd6, 32'd72, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
